// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - ALU_* : 4-bit opcode values as carried on ealuc.
//   - ALU_MASK_X / ALU_MASK_FULL : decode masks. Codes written x??? in the
//     opcode table ignore bit 3. The shift and SLT codes decode all four bits.
//   - alu_op_e : internal one-of-N operation class produced by the decoder.
//   - alu_match() : masked opcode compare used by the decoder.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;
   localparam logic [3:0] ALU_SLT = 4'b1011;

   localparam logic [3:0] ALU_MASK_X    = 4'b0111;
   localparam logic [3:0] ALU_MASK_FULL = 4'b1111;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_LUI,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_SLT
   } alu_op_e;

   function automatic logic alu_match(input logic [3:0] code,
                                      input logic [3:0] op,
                                      input logic [3:0] mask);
      return ((code ^ op) & mask) == 4'b0000;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter.
// Ports:
//   data   [31:0] in  : value to shift
//   shamt  [4:0]  in  : shift amount
//   right         in  : 1 = shift right, 0 = shift left
//   arith         in  : with right=1, replicate data[31] into vacated bits
//   result [31:0] out : shifted value
module alu_shifter (
   input  logic [31:0] data,
   input  logic [4:0]  shamt,
   input  logic        right,
   input  logic        arith,
   output logic [31:0] result
);

   logic signed [31:0] data_s;

   assign data_s = data;

   always_comb begin
      result = data << shamt;
      if (right) begin
         if (arith) begin
            result = $unsigned(data_s >>> shamt);
         end else begin
            result = data >> shamt;
         end
      end
   end

endmodule

// File: rtl/alu_core.sv
// alu_core: integer execute-stage ALU with a one-cycle registered result.
// Ports:
//   clk          in  : rising-edge clock
//   rst          in  : synchronous active-high reset, clears both outputs
//   uns          in  : unsigned variant (ADDU/SUBU/SLTU), suppresses overflow
//   alua  [31:0] in  : operand A (shift amount in alua[4:0])
//   alub  [31:0] in  : operand B
//   ealuc [3:0]  in  : operation select, decoded through alu_pkg
//   ealu  [31:0] out : registered result
//   IntOverflow  out : registered signed-overflow flag for ADD/SUB with uns=0
module alu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        uns,
   input  logic [31:0] alua,
   input  logic [31:0] alub,
   input  logic [3:0]  ealuc,
   output logic [31:0] ealu,
   output logic        IntOverflow
);

   import alu_pkg::*;

   // Signed overflow of a + b_eff. For SUB, b_eff is ~b, so the test
   // "operand signs equal, result sign differs" covers both ADD and SUB.
   function automatic logic add_ovf(input logic a_msb,
                                    input logic b_eff_msb,
                                    input logic r_msb);
      return (a_msb == b_eff_msb) && (r_msb != a_msb);
   endfunction

   alu_op_e     op;
   logic        sub_sel;
   logic [31:0] b_eff;
   logic [32:0] addsub;
   logic        ovf_raw;
   logic        slt_bit;
   logic        shift_right;
   logic        shift_arith;
   logic [31:0] shift_res;
   logic [31:0] ealu_d;
   logic        ovf_d;
   logic [31:0] ealu_q;
   logic        ovf_q;

   // Every 4-bit code resolves to exactly one operation. The fallback to
   // ADD is never reached but keeps the decoder free of latches.
   always_comb begin
      op = OP_ADD;
      if      (alu_match(ealuc, ALU_ADD, ALU_MASK_X))    op = OP_ADD;
      else if (alu_match(ealuc, ALU_SUB, ALU_MASK_X))    op = OP_SUB;
      else if (alu_match(ealuc, ALU_AND, ALU_MASK_X))    op = OP_AND;
      else if (alu_match(ealuc, ALU_OR,  ALU_MASK_X))    op = OP_OR;
      else if (alu_match(ealuc, ALU_XOR, ALU_MASK_X))    op = OP_XOR;
      else if (alu_match(ealuc, ALU_LUI, ALU_MASK_X))    op = OP_LUI;
      else if (alu_match(ealuc, ALU_SLL, ALU_MASK_FULL)) op = OP_SLL;
      else if (alu_match(ealuc, ALU_SRL, ALU_MASK_FULL)) op = OP_SRL;
      else if (alu_match(ealuc, ALU_SRA, ALU_MASK_FULL)) op = OP_SRA;
      else if (alu_match(ealuc, ALU_SLT, ALU_MASK_FULL)) op = OP_SLT;
   end

   // A single adder serves ADD, SUB and SLT. Subtraction is a + ~b + 1.
   assign sub_sel = (op == OP_SUB) || (op == OP_SLT);
   assign b_eff   = sub_sel ? ~alub : alub;
   assign addsub  = {1'b0, alua} + {1'b0, b_eff} + {32'b0, sub_sel};
   assign ovf_raw = add_ovf(alua[31], b_eff[31], addsub[31]);

   // Signed less-than is the difference sign corrected by overflow.
   // Unsigned less-than is a borrow, which is the absence of carry-out.
   assign slt_bit = uns ? ~addsub[32] : (addsub[31] ^ ovf_raw);

   assign shift_right = (op == OP_SRL) || (op == OP_SRA);
   assign shift_arith = (op == OP_SRA);

   alu_shifter u_shifter (
      .data   (alub),
      .shamt  (alua[4:0]),
      .right  (shift_right),
      .arith  (shift_arith),
      .result (shift_res)
   );

   always_comb begin
      ealu_d = addsub[31:0];
      ovf_d  = 1'b0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            ealu_d = addsub[31:0];
            ovf_d  = ovf_raw & ~uns;
         end
         OP_AND: ealu_d = alua & alub;
         OP_OR:  ealu_d = alua | alub;
         OP_XOR: ealu_d = alua ^ alub;
         OP_LUI: ealu_d = {alub[15:0], 16'h0000};
         OP_SLL, OP_SRL, OP_SRA: ealu_d = shift_res;
         OP_SLT: ealu_d = {31'b0, slt_bit};
         default: ealu_d = addsub[31:0];
      endcase
   end

   // Stage boundary: result and overflow flag registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         ealu_q <= 32'h0;
         ovf_q  <= 1'b0;
      end else begin
         ealu_q <= ealu_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ealu        = ealu_q;
   assign IntOverflow = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

   logic        clk;
   logic        rst;
   logic        uns;
   logic [31:0] alua;
   logic [31:0] alub;
   logic [3:0]  ealuc;
   logic [31:0] ealu;
   logic        IntOverflow;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   bit   have_last;
   int   checks;
   int   failures;
   bit   done;

   alu_core dut (
      .clk         (clk),
      .rst         (rst),
      .uns         (uns),
      .alua        (alua),
      .alub        (alub),
      .ealuc       (ealuc),
      .ealu        (ealu),
      .IntOverflow (IntOverflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain arithmetic on the opcode table. Overflow is judged by
   // whether the exact 64-bit signed result survives wrapping to 32 bits.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c, input logic u,
                                 output logic [31:0] r, output logic o);
      longint s;
      r = 32'h0;
      o = 1'b0;
      s = 0;
      casez (c)
         4'b?000: begin
            r = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            o = !u && (s != longint'($signed(r)));
         end
         4'b?100: begin
            r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            o = !u && (s != longint'($signed(r)));
         end
         4'b?001: r = a & b;
         4'b?101: r = a | b;
         4'b?010: r = a ^ b;
         4'b?110: r = {b[15:0], 16'h0000};
         4'b0011: r = b << a[4:0];
         4'b0111: r = b >> a[4:0];
         4'b1111: r = $unsigned($signed(b) >>> a[4:0]);
         4'b1011: r = u ? {31'b0, (a < b)} : {31'b0, ($signed(a) < $signed(b))};
         default: r = 32'h0;
      endcase
   endfunction

   // Drive one operation at the falling edge; the DUT takes it at the next
   // rising edge and the monitor checks it just after that edge.
   task automatic drive_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic u, input logic r,
                            input logic [31:0] er, input logic eo, input string tag);
      exp_t e;
      @(negedge clk);
      alua  = a;
      alub  = b;
      ealuc = c;
      uns   = u;
      rst   = r;
      e.res = er;
      e.ovf = eo;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive_model(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] c, input logic u, input logic r,
                              input string tag);
      logic [31:0] er;
      logic        eo;
      model(a, b, c, u, er, eo);
      if (r) begin
         er = 32'h0;
         eo = 1'b0;
      end
      drive_exp(a, b, c, u, r, er, eo, tag);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners[8];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h8000_0001;
      corners[5] = 32'hFFFF_FFFF;
      corners[6] = 32'hFFFF_FFFE;
      corners[7] = 32'h0000_001F;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   // Monitor: pops one expectation per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            if (!done) begin
               checks++;
               failures++;
               $display("FAIL underflow: output present with no expectation queued, ealu=%h", ealu);
            end
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (ealu !== e.res || IntOverflow !== e.ovf) begin
               failures++;
               $display("FAIL %s: ealu=%h IntOverflow=%b, required ealu=%h IntOverflow=%b",
                        e.tag, ealu, IntOverflow, e.res, e.ovf);
            end
            last_exp  = e;
            have_last = 1'b1;
         end
      end
   end

   // Output must hold until the next rising edge even though inputs move.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (have_last && !done) begin
            checks++;
            if (ealu !== last_exp.res || IntOverflow !== last_exp.ovf) begin
               failures++;
               $display("FAIL hold_%s: ealu=%h IntOverflow=%b, required ealu=%h IntOverflow=%b",
                        last_exp.tag, ealu, IntOverflow, last_exp.res, last_exp.ovf);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e0;
      checks    = 0;
      failures  = 0;
      have_last = 1'b0;
      done      = 1'b0;
      rst   = 1'b1;
      uns   = 1'b0;
      alua  = 32'h7FFF_FFFF;
      alub  = 32'h7FFF_FFFF;
      ealuc = 4'b0000;
      e0.res = 32'h0;
      e0.ovf = 1'b0;
      e0.tag = "reset0";
      exp_q.push_back(e0);
      drive_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, "reset1");

      // ADD, signed
      drive_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, "add_m1_m1");
      drive_exp(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'h7FFF_FFFE, 1'b0, "add_m1_max");
      drive_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, "add_ovf_pos");
      drive_exp(32'h8000_0001, 32'h8000_0001, 4'b1000, 1'b0, 1'b0, 32'h0000_0002, 1'b1, "add_ovf_neg");
      // SUB, signed
      drive_exp(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b1100, 1'b0, 1'b0, 32'h8000_0000, 1'b0, "sub_m1_max");
      drive_exp(32'h0000_0001, 32'h8000_0000, 4'b1100, 1'b0, 1'b0, 32'h8000_0001, 1'b1, "sub_ovf");
      drive_exp(32'h0000_0001, 32'h7FFF_FFFF, 4'b0100, 1'b0, 1'b0, 32'h8000_0002, 1'b0, "sub_1_max");
      drive_exp(32'h8000_0000, 32'hFFFF_FFFF, 4'b1100, 1'b0, 1'b0, 32'h8000_0001, 1'b0, "sub_min_m1");
      // Unsigned variants suppress overflow
      drive_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, "addu");
      drive_exp(32'h0000_0001, 32'h8000_0000, 4'b1100, 1'b1, 1'b0, 32'h8000_0001, 1'b0, "subu");
      // Logic and LUI
      drive_exp(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 1'b0, 1'b0, 32'h00F0_00F0, 1'b0, "and");
      drive_exp(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1101, 1'b0, 1'b0, 32'hFFF0_FFF0, 1'b0, "or");
      drive_exp(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0010, 1'b0, 1'b0, 32'hFF00_FF00, 1'b0, "xor");
      drive_exp(32'hF0F0_F0F0, 32'h0000_1234, 4'b1110, 1'b0, 1'b0, 32'h1234_0000, 1'b0, "lui");
      // Shifts ignore alua[31:5]
      drive_exp(32'hFFFF_FFE4, 32'h8000_0001, 4'b0011, 1'b0, 1'b0, 32'h0000_0010, 1'b0, "sll");
      drive_exp(32'h0000_0004, 32'h8000_0001, 4'b0111, 1'b0, 1'b0, 32'h0800_0000, 1'b0, "srl");
      drive_exp(32'hABCD_EF04, 32'h8000_0001, 4'b1111, 1'b0, 1'b0, 32'hF800_0000, 1'b0, "sra");
      // SLT signed vs unsigned
      drive_exp(32'hFFFF_FFFF, 32'h0000_0001, 4'b1011, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "slt");
      drive_exp(32'hFFFF_FFFF, 32'h0000_0001, 4'b1011, 1'b1, 1'b0, 32'h0000_0000, 1'b0, "sltu");
      drive_exp(32'h8000_0000, 32'h7FFF_FFFF, 4'b1011, 1'b0, 1'b0, 32'h0000_0001, 1'b0, "slt_ovf_edge");
      // Reset while an overflowing add is presented: inputs discarded
      drive_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, "pre_rst_add");
      drive_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, "rst_inflight");
      drive_exp(32'h0000_0005, 32'h0000_0003, 4'b0100, 1'b0, 1'b0, 32'h0000_0002, 1'b0, "post_rst_sub");

      // Randomized back-to-back traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [3:0]  c;
         logic        u;
         logic        r;
         a = pick_operand();
         b = pick_operand();
         c = 4'($urandom_range(0, 15));
         u = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 39) == 0);
         drive_model(a, b, c, u, r, $sformatf("rand%0d_c%h_u%0d", i, c, u));
      end

      drive_exp(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, "tail");
      @(posedge clk);
      #3;
      done = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
